// File: rtl/led_strip_pkg.sv
// Shared types and helpers for the stopwatch-game LED strip driver.
package led_strip_pkg;

  typedef enum logic [1:0] {
    MODE_DOT = 2'b00,
    MODE_BAR = 2'b01,
    MODE_OFF = 2'b10
  } led_mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SHOW = 1'b1
  } led_state_t;

  // Segment <-> LED index mapping. The legacy order is its own inverse, so
  // the same function also turns an LED index back into its segment.
  function automatic int map_index(input int idx, input logic dir, input int led_num);
    if (dir) begin
      return idx;
    end
    return (idx == 0) ? 0 : (led_num - idx);
  endfunction

endpackage

// File: rtl/led_pos_map.sv
// Turns the game counter into a segment number and an LED position.
module led_pos_map
  import led_strip_pkg::*;
#(
  parameter int LED_NUM = 10,
  parameter int CNT_LIM = 100,
  parameter int CW      = $clog2(CNT_LIM) + 1,
  parameter int LW      = $clog2(LED_NUM)
) (
  input  logic [CW-1:0] cnt_i,
  input  logic          dir_i,
  output logic          valid_o,
  output logic [LW-1:0] pos_o,
  output logic [CW-1:0] seg_o
);

  localparam int CNT_DELTA = CNT_LIM / LED_NUM;

  // Counter values past the last full segment have no LED position at all.
  always_comb begin
    seg_o   = cnt_i / CW'(CNT_DELTA);
    valid_o = (int'(cnt_i) < LED_NUM * CNT_DELTA);
    pos_o   = '0;
    if (valid_o) begin
      pos_o = LW'(map_index(int'(seg_o), dir_i, LED_NUM));
    end
  end

endmodule

// File: rtl/led_strip_ctrl.sv
// LED strip driver: live position display, stop latch with scoring, and
// a fixed-length blink of the latched LED.
module led_strip_ctrl
  import led_strip_pkg::*;
#(
  parameter int LED_NUM    = 10,
  parameter int CNT_LIM    = 100,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int HIT_BLINKS = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [$clog2(CNT_LIM):0]     cnt_i,
  input  logic [LED_NUM-1:0]           sw_i,
  input  logic [1:0]                   mode_i,
  input  logic                         dir_i,
  input  logic [$clog2(LED_NUM)-1:0]   target_i,
  input  logic                         stop_i,
  output logic [LED_NUM-1:0]           led_o,
  output logic                         hit_o,
  output logic                         busy_o
);

  localparam int CW = $clog2(CNT_LIM) + 1;
  localparam int LW = $clog2(LED_NUM);
  localparam int HW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(2 * HIT_BLINKS + 1);

  logic               map_valid;
  logic [LW-1:0]      map_pos;
  logic [CW-1:0]      map_seg;
  logic [LED_NUM-1:0] map_leds;
  logic               stop_hit;

  led_state_t         state_q, state_d;
  logic               phase_q, phase_d;
  logic [HW-1:0]      half_q, half_d;
  logic [TW-1:0]      tog_q, tog_d;
  logic [LW-1:0]      lpos_q, lpos_d;
  logic               lvalid_q, lvalid_d;
  logic               hit_d, busy_d;
  logic [LED_NUM-1:0] led_d;

  led_pos_map #(
    .LED_NUM(LED_NUM),
    .CNT_LIM(CNT_LIM),
    .CW     (CW),
    .LW     (LW)
  ) u_map (
    .cnt_i  (cnt_i),
    .dir_i  (dir_i),
    .valid_o(map_valid),
    .pos_o  (map_pos),
    .seg_o  (map_seg)
  );

  // Live strip pattern: a single dot, or every enabled LED up to the current segment.
  always_comb begin
    map_leds = '0;
    if (map_valid) begin
      for (int j = 0; j < LED_NUM; j++) begin
        if (mode_i == MODE_DOT) begin
          map_leds[j] = sw_i[j] && (j == int'(map_pos));
        end else if (mode_i == MODE_BAR) begin
          map_leds[j] = sw_i[j] && (map_index(j, dir_i, LED_NUM) <= int'(map_seg));
        end
      end
    end
  end

  // A stop scores only on a real, enabled LED matching the target.
  always_comb begin
    stop_hit = map_valid && (int'(target_i) == int'(map_pos)) && sw_i[map_pos];
  end

  // Next-state logic: RUN follows the map, SHOW blinks the latched LED.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    half_d   = half_q;
    tog_d    = tog_q;
    lpos_d   = lpos_q;
    lvalid_d = lvalid_q;
    hit_d    = hit_o;
    busy_d   = 1'b0;
    led_d    = map_leds;
    case (state_q)
      ST_RUN: begin
        if (stop_i) begin
          state_d  = ST_SHOW;
          lpos_d   = map_pos;
          lvalid_d = map_valid;
          hit_d    = stop_hit;
          phase_d  = 1'b1;
          half_d   = '0;
          tog_d    = '0;
          busy_d   = 1'b1;
          led_d    = map_valid ? (LED_NUM'(1) << map_pos) : '0;
        end
      end
      ST_SHOW: begin
        busy_d = 1'b1;
        if (half_q == HW'(BLINK_DIV - 1)) begin
          half_d  = '0;
          phase_d = ~phase_q;
          tog_d   = tog_q + 1'b1;
        end else begin
          half_d = half_q + 1'b1;
        end
        led_d = (phase_d && lvalid_q) ? (LED_NUM'(1) << lpos_q) : '0;
        if ((half_q == HW'(BLINK_DIV - 1)) && (tog_q == TW'(2 * HIT_BLINKS - 1))) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
          led_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, blink counters and all outputs are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      phase_q  <= 1'b0;
      half_q   <= '0;
      tog_q    <= '0;
      lpos_q   <= '0;
      lvalid_q <= 1'b0;
      hit_o    <= 1'b0;
      busy_o   <= 1'b0;
      led_o    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      half_q   <= half_d;
      tog_q    <= tog_d;
      lpos_q   <= lpos_d;
      lvalid_q <= lvalid_d;
      hit_o    <= hit_d;
      busy_o   <= busy_d;
      led_o    <= led_d;
    end
  end

endmodule

// File: tb/tb_led_strip_ctrl.sv
// Directed self-checking bench for led_strip_ctrl (BLINK_DIV=4, HIT_BLINKS=2).
module tb_led_strip_ctrl;

  localparam int LED_NUM = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt = '0;
  logic [9:0] sw = '1;
  logic [1:0] mode = 2'b00;
  logic       dir = 1'b0;
  logic [3:0] target = '0;
  logic       stop = 1'b0;
  logic [9:0] led;
  logic       hit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  led_strip_ctrl #(
    .LED_NUM   (10),
    .CNT_LIM   (100),
    .BLINK_DIV (4),
    .HIT_BLINKS(2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cnt_i   (cnt),
    .sw_i    (sw),
    .mode_i  (mode),
    .dir_i   (dir),
    .target_i(target),
    .stop_i  (stop),
    .led_o   (led),
    .hit_o   (hit),
    .busy_o  (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] c, input logic [9:0] s, input logic [1:0] m,
                               input logic d, input logic [3:0] t);
    cnt    = c;
    sw     = s;
    mode   = m;
    dir    = d;
    target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] eled, input logic ehit,
                             input logic ebusy);
    checks++;
    assert (led === eled) else begin
      errors++;
      $error("[TB] FAIL %s led: observed %b expected %b", tag, led, eled);
    end
    checks++;
    assert (hit === ehit) else begin
      errors++;
      $error("[TB] FAIL %s hit: observed %b expected %b", tag, hit, ehit);
    end
    checks++;
    assert (busy === ebusy) else begin
      errors++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, ebusy);
    end
  endtask

  // Pulse stop for exactly one edge; samples #1 after that edge.
  task automatic pulseStop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_led;
    int         seg;
    int         pos;

    // Reset values
    tick();
    tick();
    checkOutput("reset", 10'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // DOT, legacy direction, full sweep
    applyStimulus(8'd0, 10'h3FF, 2'b00, 1'b0, 4'd0);
    for (int c = 0; c < 100; c++) begin
      cnt = 8'(c);
      tick();
      seg = c / 10;
      pos = (seg == 0) ? 0 : 10 - seg;
      exp_led = 10'b1 << pos;
      checkOutput($sformatf("dot_sweep_%0d", c), exp_led, 1'b0, 1'b0);
    end

    // One-clock latency: change input, output holds until the next edge
    cnt = 8'd5;
    tick();
    checkOutput("lag_before", 10'b00_0000_0001, 1'b0, 1'b0);
    cnt = 8'd15;
    #2;
    checkOutput("lag_hold", 10'b00_0000_0001, 1'b0, 1'b0);
    tick();
    checkOutput("lag_after", 10'b10_0000_0000, 1'b0, 1'b0);

    // BAR mode
    applyStimulus(8'd35, 10'h3FF, 2'b01, 1'b1, 4'd0);
    tick();
    checkOutput("bar_dir1_35", 10'b00_0000_1111, 1'b0, 1'b0);
    sw = 10'b11_1111_1011;
    tick();
    checkOutput("bar_sw2_off", 10'b00_0000_1011, 1'b0, 1'b0);
    cnt = 8'd100;
    tick();
    checkOutput("bar_invalid", 10'b0, 1'b0, 1'b0);
    applyStimulus(8'd35, 10'h3FF, 2'b01, 1'b0, 4'd0);
    tick();
    checkOutput("bar_dir0_35", 10'b11_1000_0001, 1'b0, 1'b0);
    mode = 2'b11;
    tick();
    checkOutput("mode_off", 10'b0, 1'b0, 1'b0);
    applyStimulus(8'd99, 10'h3FF, 2'b00, 1'b1, 4'd0);
    tick();
    checkOutput("dot_dir1_99", 10'b10_0000_0000, 1'b0, 1'b0);

    // Async reset between edges
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 10'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("after_reset", 10'b10_0000_0000, 1'b0, 1'b0);

    // Stop hit with full blink sequence; inputs moved during SHOW are ignored
    applyStimulus(8'd47, 10'h3FF, 2'b00, 1'b1, 4'd4);
    tick();
    pulseStop();
    checkOutput("hit_k0", 10'b00_0001_0000, 1'b1, 1'b1);
    applyStimulus(8'd23, 10'h000, 2'b01, 1'b1, 4'd4);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_led = ((k < 4) || (k >= 8 && k < 12)) ? 10'b00_0001_0000 : 10'b0;
      checkOutput($sformatf("hit_k%0d", k), exp_led, 1'b1, (k < 16));
    end
    sw = 10'h3FF;
    mode = 2'b00;
    tick();
    checkOutput("hit_resume", 10'b00_0000_0100, 1'b1, 1'b0);

    // Miss on disabled LED: still blinks the latched LED
    applyStimulus(8'd47, 10'b11_1110_1111, 2'b00, 1'b1, 4'd4);
    tick();
    checkOutput("miss_map", 10'b0, 1'b1, 1'b0);
    pulseStop();
    checkOutput("miss_k0", 10'b00_0001_0000, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) tick();
    checkOutput("miss_k8", 10'b00_0001_0000, 1'b0, 1'b1);
    for (int k = 9; k <= 16; k++) tick();
    checkOutput("miss_done", 10'b0, 1'b0, 1'b0);

    // Stop pulses during SHOW and on the exit edge are ignored
    applyStimulus(8'd47, 10'h3FF, 2'b00, 1'b1, 4'd4);
    tick();
    pulseStop();
    checkOutput("ign_k0", 10'b00_0001_0000, 1'b1, 1'b1);
    applyStimulus(8'd23, 10'h3FF, 2'b00, 1'b1, 4'd5);
    for (int k = 1; k <= 4; k++) tick();
    pulseStop();
    checkOutput("ign_k5", 10'b0, 1'b1, 1'b1);
    for (int k = 6; k <= 8; k++) tick();
    checkOutput("ign_k8", 10'b00_0001_0000, 1'b1, 1'b1);
    for (int k = 9; k <= 15; k++) tick();
    checkOutput("ign_k15", 10'b0, 1'b1, 1'b1);
    pulseStop();
    checkOutput("ign_exit", 10'b0, 1'b1, 1'b0);
    tick();
    checkOutput("ign_resume", 10'b00_0000_0100, 1'b1, 1'b0);

    // Out-of-range target never scores
    applyStimulus(8'd47, 10'h3FF, 2'b00, 1'b1, 4'd10);
    tick();
    pulseStop();
    checkOutput("tgt_oor", 10'b00_0001_0000, 1'b0, 1'b1);

    // Reset mid-SHOW drops the pending blink
    tick();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_show", 10'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_show_resume", 10'b00_0001_0000, 1'b0, 1'b0);

    // Stop on an invalid count: SHOW with a dark strip
    cnt = 8'd100;
    tick();
    pulseStop();
    checkOutput("stop_invalid", 10'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
